input_taker: RTL and testbench

Nibble-serial to word-parallel deserializer. It collects N/M nibbles of M bits from the chip's narrow input pins and assembles them into an N-bit word (plaintext or key half) for the Simon core. It is the receive-side counterpart of the core's nibble-serial output path. Nibble order is least-significant first, so a word framed as bits [3:0], [7:4] … [31:28] reassembles unchanged.

---
 rtl/input_taker.sv | 73 +++++++
 tb/tb_input_taker.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/input_taker.sv
// Nibble-serial to word-parallel deserializer: gathers N/M nibbles (LSB nibble first)
// into an N-bit word and publishes it atomically on data with a one-cycle done pulse.
module input_taker #(
  parameter int N = 32,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         in_valid,
  input  logic [M-1:0] din,
  output logic [N-1:0] data,
  output logic         done,
  output logic         busy
);

  localparam int C  = N / M;
  localparam int CW = $clog2(C) + 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          state;
  logic [N-1:0]    asm_reg;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    merged;
  logic            last_nib;

  function automatic logic [N-1:0] merge_nibble(input logic [N-1:0] word,
                                                input int          idx,
                                                input logic [M-1:0] nib);
    logic [N-1:0] w;
    w = word;
    w[idx*M +: M] = nib;
    return w;
  endfunction

  // Word as it stands once the current nibble is written; on the last nibble
  // this is the value published on data.
  assign merged   = merge_nibble(asm_reg, int'(cnt), din);
  assign last_nib = (cnt == CW'(C - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      asm_reg <= '0;
      cnt     <= '0;
      data    <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // start outranks in_valid: the nibble presented with it is dropped
        state   <= COLLECT;
        asm_reg <= '0;
        cnt     <= '0;
        busy    <= 1'b1;
      end else if (state == COLLECT && in_valid) begin
        asm_reg <= merged;
        if (last_nib) begin
          data  <= merged;
          done  <= 1'b1;
          cnt   <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_input_taker.sv
// Directed and randomized bench for input_taker, checked every cycle against a
// queue-based model of the nibble framing rules.
module tb_input_taker;

  localparam int N = 32;
  localparam int M = 4;
  localparam int C = N / M;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic [M-1:0] din = '0;
  logic [N-1:0] data;
  logic         done;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state
  logic         m_armed = 1'b0;
  logic [M-1:0] m_nibs[$];
  logic [N-1:0] m_data = '0;
  logic         m_done = 1'b0;

  input_taker #(.N(N), .M(M)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .din      (din),
    .data     (data),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic s, input logic v, input logic [M-1:0] d);
    logic [N-1:0] w;
    if (r) begin
      m_armed = 1'b0;
      m_nibs.delete();
      m_data  = '0;
      m_done  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (s) begin
        m_armed = 1'b1;
        m_nibs.delete();
      end else if (m_armed && v) begin
        m_nibs.push_back(d);
        if (m_nibs.size() == C) begin
          w = '0;
          for (int i = 0; i < C; i++) w = w | (N'(m_nibs[i]) << (M * i));
          m_data  = w;
          m_done  = 1'b1;
          m_armed = 1'b0;
          m_nibs.delete();
        end
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, model at the rising edge, check just after.
  task automatic step(input logic r, input logic s, input logic v, input logic [M-1:0] d);
    reset = r; start = s; in_valid = v; din = d;
    @(posedge clk);
    model(r, s, v, d);
    #1;
    chk("data", data, m_data);
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_armed));
    cyc++;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [N-1:0] w);
    for (int i = 0; i < C; i++) step(1'b0, 1'b0, 1'b1, w[i*M +: M]);
  endtask

  initial begin
    logic [N-1:0] w;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 4'hF);
    chk("reset_data", data, 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // Basic word
    step(1'b0, 1'b1, 1'b0, '0);
    chk("basic_busy_rise", 32'(busy), 32'h1);
    send_word(32'h1234ABCD);
    chk("basic_data", data, 32'h1234ABCD);
    chk("basic_done", 32'(done), 32'h1);
    chk("basic_busy_fall", 32'(busy), 32'h0);
    step(1'b0, 1'b0, 1'b1, 4'h5);
    chk("basic_done_width", 32'(done), 32'h0);
    chk("idle_ignore_data", data, 32'h1234ABCD);

    // Gapped input
    w = 32'h1234ABCD;
    step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < C; i++) begin
      step(1'b0, 1'b0, 1'b1, w[i*M +: M]);
      if (i == 1) for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'b0, 4'h6);
      if (i == 4) step(1'b0, 1'b0, 1'b0, 4'h9);
    end
    chk("gap_data", data, 32'h1234ABCD);
    chk("gap_done", 32'(done), 32'h1);

    // Abort and restart
    step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 4'hF);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("abort_no_done", 32'(done), 32'h0);
    send_word(32'h89ABCDEF);
    chk("abort_data", data, 32'h89ABCDEF);

    // start and in_valid together: the 7 is dropped
    step(1'b0, 1'b1, 1'b1, 4'h7);
    send_word(32'h00000001);
    chk("start_iv_data", data, 32'h00000001);

    // Reset mid-word, then idle noise
    step(1'b0, 1'b1, 1'b0, '0);
    send_word(32'hCAFEBABE);
    chk("cafe_data", data, 32'hCAFEBABE);
    step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'(i + 3));
    step(1'b1, 1'b0, 1'b1, 4'h2);
    chk("midreset_data", data, 32'h0);
    chk("midreset_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'(i % 2), 4'(i));
    chk("noise_data", data, 32'h0);
    chk("noise_done", 32'(done), 32'h0);

    // Back-to-back: start issued in the done cycle
    step(1'b0, 1'b1, 1'b0, '0);
    send_word(32'h11111111);
    chk("b2b_first", data, 32'h11111111);
    step(1'b0, 1'b1, 1'b1, 4'hE);
    chk("b2b_hold", data, 32'h11111111);
    send_word(32'h22222222);
    chk("b2b_second", data, 32'h22222222);
    chk("b2b_done", 32'(done), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), 4'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
